bram_arbiter: RTL and testbench

- Two-requester round-robin arbiter sharing the single-port 8-word block memory (wen/ren/addr/datw/datr, 1-cycle registered-address read).
- Port A: HLS accelerator datapath. Port B: host/cosim loader.
- One access is granted per cycle, and read data is returned with a valid strobe one cycle after the grant.
- Sits between the requesters and the block memory instance in the cosim top.

---
 rtl/bram_arb_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 44 ++++
 rtl/bram_arbiter.sv | 130 +++++++++++++
 tb/tb_bram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port block-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bram_arb_pkg;

  // Port indices used for request/grant vectors.
  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  // Byte address to word address shift (32-bit words).
  localparam int WORD_SHIFT = 2;

  // Widest requester bundle carried internally; the top casts its
  // parameterised buses into and out of this shape.
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_bundle_t;

  // Which port wins a tie on the next contended cycle.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered priority bit.
// Latency: grant is combinational from req in the same cycle.
// Backpressure: a losing requester simply sees no grant and holds its request.
module rr_arb2
  import bram_arb_pkg::*;
#(
  parameter int RESET_PRIO = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam prio_e RST_PRIO = (RESET_PRIO == PORT_B) ? PRIO_B : PRIO_A;

  prio_e prio_q;
  prio_e prio_d;

  // Priority register: returns to the configured port on reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      prio_q <= RST_PRIO;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Grant decode and next priority; any grant hands priority to the other port.
  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (!sys_rst) begin
      if (req[PORT_A] && (!req[PORT_B] || (prio_q == PRIO_A))) begin
        gnt[PORT_A] = 1'b1;
        prio_d      = PRIO_B;
      end else if (req[PORT_B]) begin
        gnt[PORT_B] = 1'b1;
        prio_d      = PRIO_A;
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin sharing of one single-port block memory between ports A and B.
// Latency: grant and memory strobes same cycle; read data valid one cycle after grant.
// Backpressure: requester holds req/we/addr/wdata until gnt; one access per cycle.
// Optional build macro BRAM_ARB_RANGE_CHECK_EN: out-of-range words raise err and are not issued.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 8,
  parameter int RESET_PRIO = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datw,
  input  logic [DATA_W-1:0] mem_datr,

  output logic              err
);

  req_bundle_t bus_a;
  req_bundle_t bus_b;
  req_bundle_t sel;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        any_gnt;
  logic        oor;
  logic        rd_zero;
  logic        rv_a;
  logic        rv_b;

  // Gather each requester into the shared bundle shape.
  always_comb begin
    bus_a.req   = a_req;
    bus_a.we    = a_we;
    bus_a.addr  = REQ_ADDR_W'(a_addr);
    bus_a.wdata = REQ_DATA_W'(a_wdata);
    bus_b.req   = b_req;
    bus_b.we    = b_we;
    bus_b.addr  = REQ_ADDR_W'(b_addr);
    bus_b.wdata = REQ_DATA_W'(b_wdata);
    req         = 2'b00;
    req[PORT_A] = a_req;
    req[PORT_B] = b_req;
  end

  rr_arb2 #(
    .RESET_PRIO (RESET_PRIO)
  ) u_arb (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req     (req),
    .gnt     (gnt)
  );

  assign a_gnt   = gnt[PORT_A];
  assign b_gnt   = gnt[PORT_B];
  assign any_gnt = |gnt;

  // Port mux: B only when B holds the grant; idle cycles show A (don't care).
  always_comb begin
    sel = bus_a;
    if (gnt[PORT_B]) begin
      sel = bus_b;
    end
  end

`ifdef BRAM_ARB_RANGE_CHECK_EN
  // Word index beyond the memory depth: accept the request but do not issue it.
  assign oor = any_gnt && ((sel.addr >> WORD_SHIFT) >= REQ_ADDR_W'(DEPTH));
`else
  assign oor = 1'b0;
`endif

  assign mem_addr = ADDR_W'(sel.addr);
  assign mem_datw = DATA_W'(sel.wdata);
  assign mem_wen  = any_gnt & sel.req &  sel.we & ~oor;
  assign mem_ren  = any_gnt & sel.req & ~sel.we & ~oor;
  assign err      = oor;

  // Read-return strobes: one cycle after a read grant; dropped by reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rv_a <= 1'b0;
      rv_b <= 1'b0;
    end else begin
      rv_a <= gnt[PORT_A] & ~a_we;
      rv_b <= gnt[PORT_B] & ~b_we;
    end
  end

`ifdef BRAM_ARB_RANGE_CHECK_EN
  // Remember that the returning read was rejected so its data reads as zero.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_zero <= 1'b0;
    end else begin
      rd_zero <= oor;
    end
  end
`else
  assign rd_zero = 1'b0;
`endif

  assign a_rvalid = rv_a;
  assign b_rvalid = rv_b;
  assign a_rdata  = rd_zero ? '0 : mem_datr;
  assign b_rdata  = rd_zero ? '0 : mem_datr;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a behavioural 8-word memory.
// Latency: expectations carry the cycle index in which each event must appear.
// Backpressure: requests are held for the exact cycles the hand schedule grants them.
module tb_bram_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;

`ifdef BRAM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr, mem_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata, mem_datw, mem_datr, a_rdata, b_rdata;
  logic              a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wen, mem_ren, err;

  bram_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PRIO(0)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_datw(mem_datw), .mem_datr(mem_datr), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  // Block memory model: 8 words, address truncated, registered read address.
  logic [DATA_W-1:0] mem [0:7];
  logic [2:0]        raddr;
  logic              mem_clr;
  always @(posedge sys_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      raddr <= '0;
    end else begin
      if (mem_wen) mem[mem_addr[4:2]] <= mem_datw;
      if (mem_ren) raddr <= mem_addr[4:2];
    end
  end
  assign mem_datr = mem[raddr];

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    int                port;
    logic              wen, ren, err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] datw;
  } gexp_t;
  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] dat;
  } rexp_t;

  gexp_t gq[$];
  rexp_t aq[$];
  rexp_t bq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_a(input logic r, input logic w, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
    a_req = r; a_we = w; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
    b_req = r; b_we = w; b_addr = ad; b_wdata = d;
  endtask

  // Expected grant this cycle; oor marks a word index at or beyond DEPTH.
  task automatic exp_grant(input int port, input logic w, input logic [ADDR_W-1:0] ad,
                           input logic [DATA_W-1:0] d, input logic oor);
    gexp_t g;
    logic  rej;
    rej    = oor & RC;
    g.cyc  = cyc;
    g.port = port;
    g.wen  = w & ~rej;
    g.ren  = ~w & ~rej;
    g.err  = rej;
    g.addr = ad;
    g.datw = d;
    gq.push_back(g);
  endtask

  // Expected read return on the cycle after the current grant.
  task automatic exp_read(input int port, input logic [DATA_W-1:0] d);
    rexp_t r;
    r.cyc = cyc + 1;
    r.dat = d;
    if (port == 0) aq.push_back(r);
    else           bq.push_back(r);
  endtask

  task automatic check_reset(input string name);
    logic [6:0] got;
    got = {a_gnt, b_gnt, mem_wen, mem_ren, err, a_rvalid, b_rvalid};
    n_tests++;
    if (got !== 7'b0) begin
      n_fail++;
      $display("FAIL %s got {a_gnt,b_gnt,wen,ren,err,a_rv,b_rv}=%b expected 0000000", name, got);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  initial begin : monitor
    gexp_t g;
    rexp_t r;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst) begin
        if (a_gnt || b_gnt) begin
          n_tests++;
          if (gq.size() == 0) begin
            n_fail++;
            $display("FAIL grant_unexpected cyc=%0d a_gnt=%b b_gnt=%b addr=%h", cyc, a_gnt, b_gnt, mem_addr);
          end else begin
            g = gq.pop_front();
            if (cyc != g.cyc || a_gnt !== (g.port == 0) || b_gnt !== (g.port == 1) ||
                mem_wen !== g.wen || mem_ren !== g.ren || err !== g.err ||
                mem_addr !== g.addr || mem_datw !== g.datw) begin
              n_fail++;
              $display("FAIL grant cyc=%0d a_gnt=%b b_gnt=%b wen=%b ren=%b err=%b addr=%h datw=%h; expected cyc=%0d port=%0d wen=%b ren=%b err=%b addr=%h datw=%h",
                       cyc, a_gnt, b_gnt, mem_wen, mem_ren, err, mem_addr, mem_datw,
                       g.cyc, g.port, g.wen, g.ren, g.err, g.addr, g.datw);
            end
          end
        end else begin
          n_tests++;
          if (mem_wen || mem_ren || err) begin
            n_fail++;
            $display("FAIL idle_strobes cyc=%0d wen=%b ren=%b err=%b expected 000", cyc, mem_wen, mem_ren, err);
          end
        end
      end
      if (a_rvalid) begin
        n_tests++;
        if (aq.size() == 0) begin
          n_fail++;
          $display("FAIL a_rvalid_unexpected cyc=%0d a_rdata=%h", cyc, a_rdata);
        end else begin
          r = aq.pop_front();
          if (cyc != r.cyc || a_rdata !== r.dat) begin
            n_fail++;
            $display("FAIL a_read cyc=%0d data=%h expected cyc=%0d data=%h", cyc, a_rdata, r.cyc, r.dat);
          end
        end
      end
      if (b_rvalid) begin
        n_tests++;
        if (bq.size() == 0) begin
          n_fail++;
          $display("FAIL b_rvalid_unexpected cyc=%0d b_rdata=%h", cyc, b_rdata);
        end else begin
          r = bq.pop_front();
          if (cyc != r.cyc || b_rdata !== r.dat) begin
            n_fail++;
            $display("FAIL b_read cyc=%0d data=%h expected cyc=%0d data=%h", cyc, b_rdata, r.cyc, r.dat);
          end
        end
      end
    end
  end

  // Directed stimulus with hand-scheduled grants.
  initial begin : stim
    sys_rst = 1'b1;
    mem_clr = 1'b1;
    set_a(1'b1, 1'b0, 32'h0, 32'h0);
    set_b(1'b1, 1'b1, 32'h4, 32'h0);
    @(negedge sys_clk);
    check_reset("reset_hold");
    tick();
    mem_clr = 1'b0;
    sys_rst = 1'b0;
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // A write then A read of the same address.
    set_a(1'b1, 1'b1, 32'h08, 32'hDEADBEEF);
    exp_grant(0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0);
    tick();
    set_a(1'b1, 1'b0, 32'h08, 32'h0);
    exp_grant(0, 1'b0, 32'h08, 32'h0, 1'b0);
    exp_read(0, 32'hDEADBEEF);
    tick();

    // Priority is B: B write wins, A read of same word follows with new data.
    set_a(1'b1, 1'b0, 32'h04, 32'h0);
    set_b(1'b1, 1'b1, 32'h04, 32'h12345678);
    exp_grant(1, 1'b1, 32'h04, 32'h12345678, 1'b0);
    tick();
    set_b(1'b0, 1'b0, 32'h0, 32'h0);
    exp_grant(0, 1'b0, 32'h04, 32'h0, 1'b0);
    exp_read(0, 32'h12345678);
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset pulse, then both ports read continuously for six cycles.
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_reset("reset_pulse");
    tick();
    sys_rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      set_a(1'b1, 1'b0, 32'h08, 32'h0);
      set_b(1'b1, 1'b0, 32'h04, 32'h0);
      if (i % 2 == 0) begin
        exp_grant(0, 1'b0, 32'h08, 32'h0, 1'b0);
        exp_read(0, 32'hDEADBEEF);
      end else begin
        exp_grant(1, 1'b0, 32'h04, 32'h0, 1'b0);
        exp_read(1, 32'h12345678);
      end
      tick();
    end
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset the cycle after a read grant: its rvalid must never appear.
    set_a(1'b1, 1'b0, 32'h08, 32'h0);
    exp_grant(0, 1'b0, 32'h08, 32'h0, 1'b0);
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_reset("reset_midop");
    tick();
    sys_rst = 1'b0;
    tick();
    tick();
    // Priority is back to A after reset even though B was next before it.
    set_a(1'b1, 1'b0, 32'h08, 32'h0);
    set_b(1'b1, 1'b0, 32'h04, 32'h0);
    exp_grant(0, 1'b0, 32'h08, 32'h0, 1'b0);
    exp_read(0, 32'hDEADBEEF);
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    exp_grant(1, 1'b0, 32'h04, 32'h0, 1'b0);
    exp_read(1, 32'h12345678);
    tick();
    set_b(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Out-of-range read (word 8): rejected with zero data, or wraps to word 0.
    set_a(1'b1, 1'b0, 32'h20, 32'h0);
    exp_grant(0, 1'b0, 32'h20, 32'h0, 1'b1);
    exp_read(0, 32'h0);
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    // Out-of-range write (word 9): suppressed, or wraps to word 1.
    set_b(1'b1, 1'b1, 32'h24, 32'hCAFEF00D);
    exp_grant(1, 1'b1, 32'h24, 32'hCAFEF00D, 1'b1);
    tick();
    set_b(1'b1, 1'b0, 32'h04, 32'h0);
    exp_grant(1, 1'b0, 32'h04, 32'h0, 1'b0);
    exp_read(1, RC ? 32'h12345678 : 32'hCAFEF00D);
    tick();
    set_b(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    tick();

    // Anything still queued was never presented by the DUT.
    while (gq.size() != 0) begin
      gexp_t g;
      g = gq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL grant_missing expected cyc=%0d port=%0d addr=%h got none", g.cyc, g.port, g.addr);
    end
    while (aq.size() != 0) begin
      rexp_t r;
      r = aq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL a_read_missing expected cyc=%0d data=%h got none", r.cyc, r.dat);
    end
    while (bq.size() != 0) begin
      rexp_t r;
      r = bq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL b_read_missing expected cyc=%0d data=%h got none", r.cyc, r.dat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
